// File: rtl/alu_mdu_seq.sv
`default_nettype none
// ---- alu_mdu_seq : single-cycle ALU plus sequential shift-add multiplier / restoring divider (rev 1.0) ----
module alu_mdu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] y_out,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [SHW-1:0] C_CNT_ONE  = SHW'(1);
  localparam logic [SHW-1:0] C_CNT_LAST = SHW'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic               w_busy;
  logic               w_done;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_neg;
  logic               r_cc;
  logic [SHW-1:0]     r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_y;
  logic               r_n, r_z, r_c, r_v;
  logic               r_dz;

  logic               w_valid;
  logic               w_is_mul;
  logic               w_is_smul;
  logic               w_is_div;
  logic               w_cin;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_c;
  logic               w_alu_v;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_b_nz;
  logic               w_last;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_div_t;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_rem;
  logic [WIDTH-1:0]   w_div_quo;

  assign w_shamt = B_in[SHW-1:0];
  assign w_b_nz  = |B_in;
  assign w_last  = (r_cnt == C_CNT_LAST);

  // Opcode decode and single-cycle ALU, all from the live inputs at the accept edge.
  always_comb begin
    w_valid   = 1'b1;
    w_is_mul  = 1'b0;
    w_is_smul = 1'b0;
    w_is_div  = 1'b0;
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    w_cin     = opcode[3] & r_c;
    w_add     = {1'b0, A_in} + {1'b0, B_in} + {{WIDTH{1'b0}}, w_cin};
    w_sub     = {1'b0, A_in} - {1'b0, B_in} - {{WIDTH{1'b0}}, w_cin};
    if (!opcode[5]) begin
      case (opcode[3:0])
        4'b0000, 4'b1000: begin
          w_alu_res = w_add[WIDTH-1:0];
          w_alu_c   = w_add[WIDTH];
          w_alu_v   = (A_in[WIDTH-1] == B_in[WIDTH-1]) && (w_add[WIDTH-1] != A_in[WIDTH-1]);
        end
        4'b0100, 4'b1100: begin
          w_alu_res = w_sub[WIDTH-1:0];
          w_alu_c   = w_sub[WIDTH];
          w_alu_v   = (A_in[WIDTH-1] != B_in[WIDTH-1]) && (w_sub[WIDTH-1] != A_in[WIDTH-1]);
        end
        4'b0001: w_alu_res = A_in & B_in;
        4'b0101: w_alu_res = A_in & ~B_in;
        4'b0010: w_alu_res = A_in | B_in;
        4'b0110: w_alu_res = A_in | ~B_in;
        4'b0011: w_alu_res = A_in ^ B_in;
        4'b0111: w_alu_res = ~(A_in ^ B_in);
        4'b1010: w_is_mul = 1'b1;
        4'b1011: begin
          w_is_mul  = 1'b1;
          w_is_smul = 1'b1;
        end
        4'b1110: w_is_div = 1'b1;
        default: w_valid = 1'b0;
      endcase
    end else if (!opcode[4]) begin
      case (opcode[3:0])
        4'b0101: w_alu_res = A_in << w_shamt;
        4'b0110: w_alu_res = A_in >> w_shamt;
        4'b0111: w_alu_res = $signed(A_in) >>> w_shamt;
        default: w_valid = 1'b0;
      endcase
    end else begin
      w_valid = 1'b0;
    end
    w_mag_a = (w_is_smul && A_in[WIDTH-1]) ? -A_in : A_in;
    w_mag_b = (w_is_smul && B_in[WIDTH-1]) ? -B_in : B_in;
  end

  // One radix-2 step each: multiplier shifts out of r_lo, divider shifts quotient into it.
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_lo[WIDTH-1:1]};
  assign w_prod     = r_neg ? -w_mul_next : w_mul_next;
  assign w_div_t    = {r_hi, r_lo[WIDTH-1]};
  assign w_div_diff = w_div_t - {1'b0, r_mcand};
  assign w_div_ge   = ~w_div_diff[WIDTH];
  assign w_div_rem  = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_t[WIDTH-1:0];
  assign w_div_quo  = {r_lo[WIDTH-2:0], w_div_ge};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_is_mul)                 w_next = S_MUL;
          else if (w_is_div && w_b_nz)  w_next = S_DIV;
          else                          w_next = S_DONE;
        end
      end
      S_MUL, S_DIV: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_mcand  <= '0;
      r_neg    <= 1'b0;
      r_cc     <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_y      <= '0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_dz <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cc    <= opcode[4];
            r_cnt   <= '0;
            r_neg   <= w_is_smul & (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
            r_hi    <= '0;
            r_lo    <= w_is_mul ? w_mag_b : A_in;
            r_mcand <= w_is_mul ? w_mag_a : B_in;
            if (w_is_div && !w_b_nz) begin
              r_result <= '1;
              r_y      <= A_in;
              r_dz     <= 1'b1;
              if (opcode[4]) {r_n, r_z, r_c, r_v} <= 4'b1000;
            end else if (!w_valid) begin
              r_result <= '0;
            end else if (!w_is_mul && !w_is_div) begin
              r_result <= w_alu_res;
              if (opcode[4]) begin
                r_n <= w_alu_res[WIDTH-1];
                r_z <= (w_alu_res == '0);
                r_c <= w_alu_c;
                r_v <= w_alu_v;
              end
            end
          end
        end
        S_MUL: begin
          r_cnt        <= r_cnt + C_CNT_ONE;
          {r_hi, r_lo} <= w_mul_next;
          if (w_last) begin
            r_result <= w_prod[WIDTH-1:0];
            r_y      <= w_prod[2*WIDTH-1:WIDTH];
            if (r_cc) begin
              r_n <= w_prod[WIDTH-1];
              r_z <= (w_prod[WIDTH-1:0] == '0);
              r_c <= 1'b0;
              r_v <= 1'b0;
            end
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + C_CNT_ONE;
          r_hi  <= w_div_rem;
          r_lo  <= w_div_quo;
          if (w_last) begin
            r_result <= w_div_quo;
            r_y      <= w_div_rem;
            if (r_cc) begin
              r_n <= w_div_quo[WIDTH-1];
              r_z <= (w_div_quo == '0);
              r_c <= 1'b0;
              r_v <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy     = w_busy;
  assign done     = w_done;
  assign result   = r_result;
  assign y_out    = r_y;
  assign N        = r_n;
  assign Z        = r_z;
  assign C        = r_c;
  assign V        = r_v;
  assign div_zero = r_dz;

endmodule
`default_nettype wire
